spi_target_rx: RTL and testbench
================================

Name: spi_target_rx

Overview:
- SPI target (receive-only) for the far end of the SPI/LCD link driven by spi_controller.
- Oversamples spi_clk, spi_mosi, spi_cs_n and lcd_dc on the system clock, then assembles MSB-first bytes in SPI mode 0.
- Each byte is tagged with its lcd_dc value and buffered in a FIFO.
- The FIFO is exposed to the CPU through the same word-addressed memory-mapped bus used by spi_controller.
- Used as an on-chip loopback/monitor target and as a board-level LCD emulator.

Parameters:
FIFO_DEPTH, 8, number of {dc,byte} entries; power of two, 2..64
SYNC_STAGES, 2, synchronizer flops on each SPI input; minimum 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
spi_clk  input  1  SPI clock from initiator, asynchronous to clk
spi_mosi  input  1  serial data, MSB first
spi_cs_n  input  1  chip select, active low
lcd_dc  input  1  data/command flag, sampled with last bit of each byte
address_in  input  32  bus byte address; bits [3:2] decoded
sel_in  input  1  bus access strobe, one cycle per access
read_in  input  1  1 = read, 0 = write
write_mask_in  input  4  byte enables; byte 0 must be set for any write effect
write_value_in  input  32  write data
read_value_out  output  32  read data
ready_out  output  1  access complete
irq_out  output  1  level interrupt: FIFO not empty AND CTRL.irq_en

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - read_value_out=0, ready_out=0, irq_out=0.
  - FIFO empty; flags clear; byte counter 0; CTRL=0 (receiver disabled).
- Input synchronization:
  - All four SPI inputs pass through SYNC_STAGES flops.
  - A rising edge is detected when the previous synced spi_clk is 0 and the current one is 1.
  - Supported spi_clk frequency ≤ clk/4.
- Receive FSM, states IDLE, SHIFT, PUSH:
  - IDLE: bit_cnt=0. Go to SHIFT when CTRL.en=1 and synced cs_n=0.
  - SHIFT: on each rising edge, shift_reg <= {shift_reg[6:0], mosi} and bit_cnt++. On the 8th edge, latch dc and go to PUSH.
  - SHIFT: if cs_n rises with bit_cnt≠0, discard the partial byte, set STATUS.frame_err, and go to IDLE. If cs_n rises with bit_cnt=0, go to IDLE silently.
  - PUSH (one cycle): write {dc, byte} to the FIFO and increment byte_count (16-bit, wraps 0xFFFF→0). Return to SHIFT if cs_n=0, otherwise IDLE. The cycle budget guarantees no edge is lost.
  - CTRL.en=0 at any time forces IDLE and clears shift_reg and bit_cnt. FIFO contents are kept.
- FIFO:
  - Push when full: the entry is dropped and STATUS.overflow is set (sticky). byte_count still increments.
  - Push and pop in the same cycle: both take effect; count is unchanged. This applies when full too, so the push is accepted.
  - Flush in the same cycle as a push: flush wins; FIFO ends empty.
- Register map (address[3:2]):
  - 0x00 RX_DATA (R): returns {valid, 22'b0, dc, byte[7:0]} with valid at bit 31. A read pops one entry when non-empty. When empty it returns 0 and causes no state change. Writes are ignored.
  - 0x04 CTRL (R/W): bit0 en, bit1 irq_en. bit2 flush is write-1, self-clearing, and reads as 0.
  - 0x08 STATUS (R): bit0 not_empty, bit1 full, bit2 overflow, bit3 frame_err, bit4 busy (FSM≠IDLE), bits[14:8] fill count.
  - 0x08 STATUS (W): writing 1 to bit2 or bit3 clears that bit (W1C). If a set event occurs in the same cycle, set wins.
  - 0x0C BYTE_COUNT (R): {16'b0, byte_count}. Any write with byte 0 enabled clears it.
- Bus timing:
  - The access is sampled on the clk edge where sel_in=1.
  - ready_out=1 for exactly the following cycle, with read_value_out valid in that cycle. read_value_out returns to 0 afterwards.
  - Writes also produce a one-cycle ready_out.
  - sel_in asserted on back-to-back cycles is accepted each cycle.
  - Unmapped address bits above [3:2] are ignored.
- Reset mid-byte or mid-access: everything returns immediately to the reset values; no partial byte is stored.

Test Plan:
- Reset, write CTRL=0x1, drive cs_n=0, shift 0xA5 with dc=1 at clk/8, raise cs_n → STATUS=0x0000_0101; RX_DATA read = 0x8000_01A5; next RX_DATA read = 0x0000_0000; BYTE_COUNT=1.
- Send 9 bytes 0x00..0x08 with FIFO_DEPTH=8, no reads → STATUS bits full=1 and overflow=1, count=8; eight reads return 0x00..0x07 in order; write STATUS=0x4 → overflow cleared.
- cs_n rises after 5 bits → no push, frame_err=1, FSM IDLE; the next full byte 0x3C is received correctly.
- FIFO full, RX_DATA read in the same cycle as a byte push → count stays 8; the oldest entry is returned and the new byte is retained at the tail.
- CTRL.en=0 during a byte → partial byte discarded, busy=0; write CTRL=0x5 (flush+en) → count=0; irq_out=0 with irq_en=0, and 1 after the next byte once irq_en=1.
- Assert reset mid-byte with 3 entries queued → all outputs 0, STATUS=0, BYTE_COUNT=0 after release.

Source files
------------

// File: rtl/spi_target_rx.sv
// Receive-only SPI mode-0 target: oversamples the link on clk, assembles MSB-first
// bytes tagged with lcd_dc and queues them in a FIFO read over the word-addressed bus.
module spi_target_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  input  logic        lcd_dc,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  output logic        ready_out,
  output logic        irq_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q, dc_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, mosi_s, csn_s, dc_s, sclk_rise;
  state_e                 state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   dc_q;
  logic [8:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   en_q, irq_en_q, overflow_q, frame_err_q;
  logic [15:0]            byte_cnt_q;
  logic                   ready_q;
  logic [31:0]            rdata_q, rdata_d;
  logic [1:0]             reg_sel;
  logic                   wr_acc, rd_acc, fifo_empty, fifo_full;
  logic                   pop, flush, push, push_ok, overflow_set, frame_err_set;
  logic                   unused_bits;

  assign unused_bits = ^{address_in[31:4], address_in[1:0], write_mask_in[3:1],
                         write_value_in[31:4]};

  // cs_n synchronizer resets high so a deasserted select is seen as idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      dc_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], lcd_dc};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  assign reg_sel       = address_in[3:2];
  assign wr_acc        = sel_in & ~read_in & write_mask_in[0];
  assign rd_acc        = sel_in & read_in;
  assign fifo_empty    = (count_q == '0);
  assign fifo_full     = (count_q == DEPTH_C);
  assign pop           = rd_acc && (reg_sel == 2'd0) && !fifo_empty;
  assign flush         = wr_acc && (reg_sel == 2'd1) && write_value_in[2];
  assign push          = (state_q == PUSH) && en_q;
  assign push_ok       = push && (!fifo_full || pop);
  assign overflow_set  = push && fifo_full && !pop && !flush;
  assign frame_err_set = en_q && (state_q == SHIFT) && csn_s && (bit_cnt_q != 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      dc_q      <= 1'b0;
    end else if (!en_q) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          if (!csn_s) state_q <= SHIFT;
        end
        SHIFT: begin
          if (csn_s) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end else if (sclk_rise) begin
            shift_q   <= {shift_q[6:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              dc_q    <= dc_s;
              state_q <= PUSH;
            end
          end
        end
        PUSH:    state_q <= csn_s ? IDLE : SHIFT;
        default: state_q <= IDLE;
      endcase
    end
  end

  // a pop frees a slot in the same cycle, so a push into a full FIFO is kept
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop) count_d = count_q + CW'(1);
      else if (pop && !push_ok) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= {dc_q, shift_q};
  end

  always_comb begin
    rdata_d = '0;
    if (rd_acc) begin
      case (reg_sel)
        2'd0:    if (!fifo_empty) rdata_d = {1'b1, 22'b0, mem_q[rd_ptr_q]};
        2'd1:    rdata_d = {30'b0, irq_en_q, en_q};
        2'd2:    rdata_d = {17'b0, 7'(count_q), 3'b0, (state_q != IDLE), frame_err_q,
                            overflow_q, fifo_full, !fifo_empty};
        default: rdata_d = {16'b0, byte_cnt_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      byte_cnt_q  <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= sel_in;
      rdata_q  <= rdata_d;
      if (wr_acc && reg_sel == 2'd1) begin
        en_q     <= write_value_in[0];
        irq_en_q <= write_value_in[1];
      end
      if (wr_acc && reg_sel == 2'd2 && write_value_in[2]) overflow_q <= 1'b0;
      if (wr_acc && reg_sel == 2'd2 && write_value_in[3]) frame_err_q <= 1'b0;
      if (overflow_set) overflow_q <= 1'b1;
      if (frame_err_set) frame_err_q <= 1'b1;
      if (wr_acc && reg_sel == 2'd3) byte_cnt_q <= '0;
      else if (push) byte_cnt_q <= byte_cnt_q + 16'd1;
    end
  end

  assign read_value_out = rdata_q;
  assign ready_out      = ready_q;
  assign irq_out        = !fifo_empty && irq_en_q;
endmodule

// File: tb/tb_spi_target_rx.sv
// Self-checking bench for spi_target_rx: drives SPI frames and bus accesses and
// compares register reads against a queue-based model of the receiver.
module tb_spi_target_rx;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_clk, spi_mosi, spi_cs_n, lcd_dc;
  logic [31:0] address_in;
  logic        sel_in, read_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;
  logic        ready_out, irq_out;

  int checks = 0;
  int errors = 0;

  logic [8:0]  modelQ[$];
  logic        mOverflow, mFrameErr, mIrqEn;
  logic [15:0] mByteCount;

  spi_target_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .lcd_dc(lcd_dc), .address_in(address_in), .sel_in(sel_in),
    .read_in(read_in), .write_mask_in(write_mask_in), .write_value_in(write_value_in),
    .read_value_out(read_value_out), .ready_out(ready_out), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the bench completed");
    $fatal(1, "[TB] timeout");
  end

  // Reference model: a plain queue of {dc, byte} plus sticky flags.
  function automatic void modelReset();
    modelQ.delete();
    mOverflow  = 1'b0;
    mFrameErr  = 1'b0;
    mIrqEn     = 1'b0;
    mByteCount = 16'd0;
  endfunction

  function automatic void modelByte(input logic [7:0] b, input logic dc);
    mByteCount = mByteCount + 16'd1;
    if (modelQ.size() == DEPTH) mOverflow = 1'b1;
    else modelQ.push_back({dc, b});
  endfunction

  function automatic logic [31:0] modelRead();
    logic [8:0] e;
    if (modelQ.size() == 0) return 32'h0;
    e = modelQ.pop_front();
    return {1'b1, 22'b0, e};
  endfunction

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s = '0;
    s[0] = (modelQ.size() != 0);
    s[1] = (modelQ.size() == DEPTH);
    s[2] = mOverflow;
    s[3] = mFrameErr;
    s[14:8] = 7'(modelQ.size());
    return s;
  endfunction

  // Bus tasks start and end on a falling clock edge.
  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, output logic rdy);
    sel_in = 1'b1; read_in = 1'b0; address_in = addr;
    write_mask_in = mask; write_value_in = data;
    @(negedge clk);
    rdy = ready_out;
    sel_in = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
    sel_in = 1'b1; read_in = 1'b1; address_in = addr;
    write_mask_in = 4'h0; write_value_in = 32'h0;
    @(negedge clk);
    rdy = ready_out;
    data = read_value_out;
    sel_in = 1'b0;
  endtask

  task automatic spiBits(input logic [7:0] data, input int nbits, input logic dc, input int half);
    lcd_dc = dc;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = data[i];
      repeat (half) @(negedge clk);
      spi_clk = 1'b1;
      repeat (half) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic csLow();
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic csHigh();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic r;
    checks++;
    if (read_value_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", read_value_out); end
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", ready_out); end
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b want 0", irq_out); end
    for (int a = 0; a < 4; a++) begin
      busRead(32'(a * 4), d, r);
      checks++;
      if (d !== 32'h0 || r !== 1'b1) begin
        errors++; $display("[TB] FAIL reset_reg%0d got %h ready %b want 0 ready 1", a, d, r);
      end
    end
    busWrite(32'h4, 32'h3, 4'b1110, r);
    busRead(32'h4, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL masked_ctrl_write got %h want 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic r;
    busWrite(32'h4, 32'h1, 4'hF, r);
    checks++;
    if (r !== 1'b1) begin errors++; $display("[TB] FAIL write_ready got %b want 1", r); end
    csLow();
    spiBits(8'hA5, 8, 1'b1, 4);
    csHigh();
    modelByte(8'hA5, 1'b1);
    busRead(32'h8, d, r);
    checks++;
    if (d !== 32'h0000_0101) begin errors++; $display("[TB] FAIL basic_status got %h want 00000101", d); end
    busRead(32'h0, d, r);
    void'(modelRead());
    checks++;
    if (d !== 32'h8000_01A5) begin errors++; $display("[TB] FAIL basic_rx got %h want 800001a5", d); end
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b0 || read_value_out !== 32'h0) begin
      errors++; $display("[TB] FAIL ready_pulse got ready %b data %h want 0 0", ready_out, read_value_out);
    end
    busRead(32'h0, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL empty_rx got %h want 0", d); end
    busRead(32'hC, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("[TB] FAIL basic_count got %h want 1", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    logic r;
    csLow();
    for (int i = 0; i < 9; i++) begin
      spiBits(8'(i), 8, 1'b0, 4);
      modelByte(8'(i), 1'b0);
    end
    csHigh();
    busRead(32'h8, d, r);
    checks++;
    if (d !== modelStatus()) begin errors++; $display("[TB] FAIL ovf_status got %h want %h", d, modelStatus()); end
    for (int i = 0; i < 8; i++) begin
      busRead(32'h0, d, r);
      e = modelRead();
      checks++;
      if (d !== e || r !== 1'b1) begin
        errors++; $display("[TB] FAIL ovf_read%0d got %h ready %b want %h", i, d, r, e);
      end
    end
    busRead(32'hC, d, r);
    checks++;
    if (d !== {16'h0, mByteCount}) begin errors++; $display("[TB] FAIL ovf_count got %h want %h", d, mByteCount); end
    busWrite(32'h8, 32'h4, 4'hF, r);
    mOverflow = 1'b0;
    busRead(32'h8, d, r);
    checks++;
    if (d !== modelStatus()) begin errors++; $display("[TB] FAIL ovf_clear got %h want %h", d, modelStatus()); end
  endtask

  task automatic test_frame_err();
    logic [31:0] d, e;
    logic r, dc;
    csLow();
    spiBits(8'hFF, 5, 1'b0, 4);
    csHigh();
    mFrameErr = 1'b1;
    busRead(32'h8, d, r);
    checks++;
    if (d !== modelStatus()) begin errors++; $display("[TB] FAIL frame_status got %h want %h", d, modelStatus()); end
    dc = 1'($urandom_range(0, 1));
    csLow();
    spiBits(8'h3C, 8, dc, 4);
    csHigh();
    modelByte(8'h3C, dc);
    busRead(32'h0, d, r);
    e = modelRead();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL frame_next got %h want %h", d, e); end
    busWrite(32'h8, 32'h8, 4'hF, r);
    mFrameErr = 1'b0;
    busRead(32'h8, d, r);
    checks++;
    if (d !== modelStatus()) begin errors++; $display("[TB] FAIL frame_clear got %h want %h", d, modelStatus()); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d, e;
    logic [7:0]  b;
    logic r, dc;
    csLow();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      dc = 1'($urandom_range(0, 1));
      spiBits(b, 8, dc, 4);
      modelByte(b, dc);
    end
    b = 8'($urandom);
    dc = 1'($urandom_range(0, 1));
    spiBits(b, 7, dc, 4);
    spi_mosi = b[0];
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
    // the 8th edge reaches the FSM after SYNC+1 cycles; the push lands one cycle later
    repeat (SYNC + 1) @(negedge clk);
    busRead(32'h0, d, r);
    e = modelRead();
    modelByte(b, dc);
    spi_clk = 1'b0;
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL pushpop_read got %h want %h", d, e); end
    csHigh();
    busRead(32'h8, d, r);
    checks++;
    if (d !== modelStatus()) begin errors++; $display("[TB] FAIL pushpop_status got %h want %h", d, modelStatus()); end
    for (int i = 0; i < DEPTH; i++) begin
      busRead(32'h0, d, r);
      e = modelRead();
      checks++;
      if (d !== e) begin errors++; $display("[TB] FAIL pushpop_drain%0d got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, e, addr;
    logic [7:0]  b;
    logic r, dc;
    int n, half, k;
    for (int f = 0; f < 5; f++) begin
      n = $urandom_range(1, 4);
      half = $urandom_range(2, 4);
      csLow();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        dc = 1'($urandom_range(0, 1));
        spiBits(b, 8, dc, half);
        modelByte(b, dc);
      end
      csHigh();
      addr = $urandom;
      addr[3:2] = 2'd2;
      busRead(addr, d, r);
      checks++;
      if (d !== modelStatus()) begin errors++; $display("[TB] FAIL rand_status%0d got %h want %h", f, d, modelStatus()); end
      k = $urandom_range(0, modelQ.size() + 1);
      for (int i = 0; i < k; i++) begin
        addr = $urandom;
        addr[3:2] = 2'd0;
        busRead(addr, d, r);
        e = modelRead();
        checks++;
        if (d !== e) begin errors++; $display("[TB] FAIL rand_read%0d_%0d got %h want %h", f, i, d, e); end
      end
    end
    busRead(32'hC, d, r);
    checks++;
    if (d !== {16'h0, mByteCount}) begin errors++; $display("[TB] FAIL rand_count got %h want %h", d, mByteCount); end
    busWrite(32'hC, 32'h0, 4'h1, r);
    mByteCount = 16'd0;
    busRead(32'hC, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL count_clear got %h want 0", d); end
    mOverflow = 1'b0;
    busWrite(32'h8, 32'hC, 4'hF, r);
  endtask

  task automatic test_disable_flush_irq();
    logic [31:0] d, e;
    logic r;
    csLow();
    spiBits(8'h11, 8, 1'b0, 4);
    spiBits(8'h22, 8, 1'b1, 4);
    modelByte(8'h11, 1'b0);
    modelByte(8'h22, 1'b1);
    spiBits(8'hF0, 4, 1'b0, 4);
    busWrite(32'h4, 32'h0, 4'hF, r);
    repeat (2) @(negedge clk);
    busRead(32'h8, d, r);
    checks++;
    if (d !== modelStatus()) begin errors++; $display("[TB] FAIL disable_status got %h want %h", d, modelStatus()); end
    csHigh();
    busWrite(32'h4, 32'h5, 4'hF, r);
    modelQ.delete();
    busRead(32'h8, d, r);
    checks++;
    if (d !== modelStatus()) begin errors++; $display("[TB] FAIL flush_status got %h want %h", d, modelStatus()); end
    busRead(32'h4, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("[TB] FAIL flush_ctrl got %h want 1", d); end
    csLow();
    spiBits(8'h5A, 8, 1'b0, 4);
    csHigh();
    modelByte(8'h5A, 1'b0);
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("[TB] FAIL irq_masked got %b want 0", irq_out); end
    busWrite(32'h4, 32'h3, 4'hF, r);
    mIrqEn = 1'b1;
    @(negedge clk);
    checks++;
    if (irq_out !== (mIrqEn && modelQ.size() != 0)) begin
      errors++; $display("[TB] FAIL irq_enabled got %b want 1", irq_out);
    end
    busRead(32'h0, d, r);
    e = modelRead();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL irq_read got %h want %h", d, e); end
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("[TB] FAIL irq_drained got %b want 0", irq_out); end
    csLow();
    spiBits(8'hC3, 8, 1'b1, 3);
    csHigh();
    modelByte(8'hC3, 1'b1);
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("[TB] FAIL irq_next_byte got %b want 1", irq_out); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic r;
    csLow();
    for (int i = 0; i < 2; i++) begin
      spiBits(8'(i + 8'h40), 8, 1'b0, 4);
      modelByte(8'(i + 8'h40), 1'b0);
    end
    spiBits(8'hE7, 3, 1'b1, 4);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (read_value_out !== 32'h0 || ready_out !== 1'b0 || irq_out !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_outputs got %h %b %b want 0 0 0", read_value_out, ready_out, irq_out);
    end
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    busRead(32'h8, d, r);
    checks++;
    if (d !== modelStatus()) begin errors++; $display("[TB] FAIL midreset_status got %h want %h", d, modelStatus()); end
    busRead(32'hC, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL midreset_count got %h want 0", d); end
    busRead(32'h0, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL midreset_rx got %h want 0", d); end
    busRead(32'h4, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL midreset_ctrl got %h want 0", d); end
  endtask

  initial begin
    reset = 1'b1;
    spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; lcd_dc = 1'b0;
    address_in = '0; sel_in = 1'b0; read_in = 1'b0;
    write_mask_in = '0; write_value_in = '0;
    modelReset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_frame_err();
    test_push_pop_full();
    test_random();
    test_disable_flush_irq();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
